// File: rtl/test_status_uart_reporter.sv
`default_nettype none
// ============================================================================
// Module   : test_status_uart_reporter
// Purpose  : Watches CPU writes to the test-status CSR (tohost). It latches
//            the first nonzero value and sends one ASCII verdict on a UART
//            TX line: "PASS\r\n", or "FAIL XXXXXXXX\r\n" with the value in
//            uppercase hex.
// Revision : 1.0 - initial release
// ============================================================================
module test_status_uart_reporter #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        csr_we,
    input  logic [31:0] csr_wdata,
    output logic        serial_out,
    output logic        busy,
    output logic        done,
    output logic        pass
);

    // Clocks per serial bit. Every UART bit cell lasts exactly this many cycles.
    localparam int CPB   = CLOCK_FREQ / BAUD_RATE;
    localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;

    localparam logic [CNT_W-1:0] C_BAUD_RELOAD = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] C_BAUD_ONE    = CNT_W'(1);
    localparam logic [3:0]       C_LAST_PASS   = 4'd5;   // "PASS\r\n" has 6 bytes
    localparam logic [3:0]       C_LAST_FAIL   = 4'd14;  // "FAIL XXXXXXXX\r\n" has 15 bytes
    localparam logic [2:0]       C_LAST_BIT    = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t             state_q,  state_d;
    logic [CNT_W-1:0]   baud_q,   baud_d;
    logic [2:0]         bit_q,    bit_d;
    logic [3:0]         byte_q,   byte_d;
    logic [31:0]        value_q,  value_d;
    logic               pass_q,   pass_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;
    logic               serial_q, serial_d;

    logic [2:0]         nib_sel;
    logic [3:0]         nibble;
    logic [7:0]         hex_char;
    logic [7:0]         cur_byte;
    logic [3:0]         last_byte;
    logic               accept;

    // Build the current message byte from the byte index. The text is not stored in memory.
    always_comb begin
        nib_sel   = 3'(byte_q - 4'd5);
        nibble    = value_q[{~nib_sel, 2'b00} +: 4];
        hex_char  = (nibble < 4'd10) ? (8'h30 + {4'h0, nibble})
                                     : (8'h37 + {4'h0, nibble});
        last_byte = pass_q ? C_LAST_PASS : C_LAST_FAIL;
        cur_byte  = 8'h0A;
        if (pass_q) begin
            case (byte_q)
                4'd0:    cur_byte = 8'h50;  // P
                4'd1:    cur_byte = 8'h41;  // A
                4'd2:    cur_byte = 8'h53;  // S
                4'd3:    cur_byte = 8'h53;  // S
                4'd4:    cur_byte = 8'h0D;
                default: cur_byte = 8'h0A;
            endcase
        end else begin
            case (byte_q)
                4'd0:    cur_byte = 8'h46;  // F
                4'd1:    cur_byte = 8'h41;  // A
                4'd2:    cur_byte = 8'h49;  // I
                4'd3:    cur_byte = 8'h4C;  // L
                4'd4:    cur_byte = 8'h20;  // space
                4'd13:   cur_byte = 8'h0D;
                4'd14:   cur_byte = 8'h0A;
                default: cur_byte = hex_char;
            endcase
        end
    end

    // Compute the next state and all next register values. Every output is a flop.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        value_d  = value_q;
        pass_d   = pass_q;
        busy_d   = busy_q;
        done_d   = done_q;
        serial_d = serial_q;
        accept   = csr_we && (csr_wdata != 32'h0);

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d  = ST_START;
                    value_d  = csr_wdata;
                    pass_d   = (csr_wdata == 32'h1);
                    busy_d   = 1'b1;
                    byte_d   = 4'd0;
                    bit_d    = 3'd0;
                    baud_d   = C_BAUD_RELOAD;
                    serial_d = 1'b0;
                end
            end
            ST_START: begin
                if (baud_q == '0) begin
                    state_d  = ST_DATA;
                    bit_d    = 3'd0;
                    baud_d   = C_BAUD_RELOAD;
                    serial_d = cur_byte[0];
                end else begin
                    baud_d = baud_q - C_BAUD_ONE;
                end
            end
            ST_DATA: begin
                if (baud_q == '0) begin
                    baud_d = C_BAUD_RELOAD;
                    if (bit_q == C_LAST_BIT) begin
                        state_d  = ST_STOP;
                        serial_d = 1'b1;
                    end else begin
                        bit_d    = bit_q + 3'd1;
                        serial_d = cur_byte[3'(bit_q + 3'd1)];
                    end
                end else begin
                    baud_d = baud_q - C_BAUD_ONE;
                end
            end
            ST_STOP: begin
                if (baud_q == '0) begin
                    if (byte_q == last_byte) begin
                        state_d  = ST_DONE;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        serial_d = 1'b1;
                    end else begin
                        // The next start bit follows the stop bit directly, with no idle gap.
                        state_d  = ST_START;
                        byte_d   = byte_q + 4'd1;
                        baud_d   = C_BAUD_RELOAD;
                        serial_d = 1'b0;
                    end
                end else begin
                    baud_d = baud_q - C_BAUD_ONE;
                end
            end
            ST_DONE: begin
                // One verdict per reset: only a reset leaves this state.
                state_d = ST_DONE;
            end
            default: begin
                state_d  = ST_IDLE;
                busy_d   = 1'b0;
                serial_d = 1'b1;
            end
        endcase
    end

    // State and datapath registers. Asserting reset drives the line idle-high at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            baud_q   <= '0;
            bit_q    <= 3'd0;
            byte_q   <= 4'd0;
            value_q  <= 32'h0;
            pass_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            serial_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            value_q  <= value_d;
            pass_q   <= pass_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            serial_q <= serial_d;
        end
    end

    assign serial_out = serial_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;

endmodule
`default_nettype wire

// File: tb/tb_test_status_uart_reporter.sv
`default_nettype none
// ============================================================================
// Module   : tb_test_status_uart_reporter
// Purpose  : Directed bench for test_status_uart_reporter. A UART receiver
//            model samples each bit in the middle of its cell. The bench
//            compares the received bytes and the status flags against
//            hand-written verdict strings.
// Revision : 1.0 - initial release
// ============================================================================
module tb_test_status_uart_reporter;

    localparam int CF  = 1000;
    localparam int BR  = 100;
    localparam int CPB = 10;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        csr_we    = 1'b0;
    logic [31:0] csr_wdata = 32'h0;
    logic        serial_out;
    logic        busy;
    logic        done;
    logic        pass;

    int vecs = 0;
    int errs = 0;

    logic [7:0] rx_q[$];
    int         rx_starts  = 0;
    int         rx_framing = 0;

    typedef struct {
        logic [31:0]   wdata;
        logic          exp_pass;
        int            len;     // total bytes, including the trailing CR LF
        logic [103:0]  body;    // text without CR LF, right-justified
    } vec_t;

    test_status_uart_reporter #(
        .CLOCK_FREQ (CF),
        .BAUD_RATE  (BR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .csr_we     (csr_we),
        .csr_wdata  (csr_wdata),
        .serial_out (serial_out),
        .busy       (busy),
        .done       (done),
        .pass       (pass)
    );

    // 10-unit clock period
    always #5 clk = ~clk;

    // UART receiver model. It detects a start bit and samples each bit in the middle of its cell.
    initial begin : rx_model
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (serial_out === 1'b0) begin
                rx_starts++;
                repeat (CPB / 2 - 1) @(negedge clk);
                if (serial_out !== 1'b0) begin
                    rx_framing++;
                end else begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (CPB) @(negedge clk);
                        b[i] = serial_out;
                    end
                    repeat (CPB) @(negedge clk);
                    if (serial_out !== 1'b1) rx_framing++;
                    rx_q.push_back(b);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rx();
        rx_q.delete();
        rx_starts  = 0;
        rx_framing = 0;
    endtask

    task automatic do_reset();
        csr_we    = 1'b0;
        csr_wdata = 32'h0;
        rst_n     = 1'b0;
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();
        clear_rx();
    endtask

    // Issue one write and follow the whole message. intrude_at = k puts a
    // write of 32'h2 on the edge E+k; -1 means no extra write.
    task automatic send_and_check(input vec_t v, input int intrude_at);
        int n_cycles;
        logic [7:0] exp_b;
        logic [31:0] got_b;
        n_cycles  = 10 * CPB * v.len;
        csr_wdata = v.wdata;
        csr_we    = 1'b1;
        cyc();                                  // edge E has passed
        csr_we    = 1'b0;
        csr_wdata = 32'h0;
        check("start_bit_after_E", {31'h0, serial_out}, 32'h0);
        check("busy_after_E",      {31'h0, busy},       32'h1);
        check("pass_after_E",      {31'h0, pass},       {31'h0, v.exp_pass});
        for (int k = 1; k < n_cycles; k++) begin
            csr_we    = (k == intrude_at);
            csr_wdata = (k == intrude_at) ? 32'h2 : 32'h0;
            cyc();
        end
        check("busy_before_end", {31'h0, busy}, 32'h1);
        check("done_before_end", {31'h0, done}, 32'h0);
        csr_we    = (intrude_at == n_cycles);
        csr_wdata = (intrude_at == n_cycles) ? 32'h2 : 32'h0;
        cyc();                                  // edge E + 10*CPB*N has passed
        csr_we    = 1'b0;
        csr_wdata = 32'h0;
        check("done_at_end",   {31'h0, done},       32'h1);
        check("busy_at_end",   {31'h0, busy},       32'h0);
        check("serial_at_end", {31'h0, serial_out}, 32'h1);
        check("pass_at_end",   {31'h0, pass},       {31'h0, v.exp_pass});
        repeat (20) cyc();
        check("rx_byte_count", rx_q.size(), v.len);
        check("rx_framing",    rx_framing,  32'h0);
        for (int i = 0; i < v.len; i++) begin
            if (i < v.len - 2)       exp_b = v.body[8 * (v.len - 3 - i) +: 8];
            else if (i == v.len - 2) exp_b = 8'h0D;
            else                     exp_b = 8'h0A;
            got_b = (i < rx_q.size()) ? {24'h0, rx_q[i]} : 32'hFFFF_FFFF;
            check($sformatf("rx_byte%0d", i), got_b, {24'h0, exp_b});
        end
    endtask

    // Test sequence: the vector table first, then the multi-cycle corner cases.
    initial begin : main
        vec_t tab[5];
        vec_t v_pass;
        vec_t v_beef;

        tab[0] = '{32'h0000_0001, 1'b1, 6,  "PASS"};
        tab[1] = '{32'h0000_002A, 1'b0, 15, "FAIL 0000002A"};
        tab[2] = '{32'hFFFF_FFFF, 1'b0, 15, "FAIL FFFFFFFF"};
        tab[3] = '{32'h0000_0002, 1'b0, 15, "FAIL 00000002"};
        tab[4] = '{32'h9ABC_DEF0, 1'b0, 15, "FAIL 9ABCDEF0"};
        v_pass = tab[0];
        v_beef = '{32'hDEAD_BEEF, 1'b0, 15, "FAIL DEADBEEF"};

        // Reset, then idle with no traffic on the line.
        do_reset();
        repeat (50) cyc();
        check("idle_serial", {31'h0, serial_out}, 32'h1);
        check("idle_busy",   {31'h0, busy},       32'h0);
        check("idle_done",   {31'h0, done},       32'h0);
        check("idle_pass",   {31'h0, pass},       32'h0);
        check("idle_starts", rx_starts,           32'h0);

        // Table-driven verdict messages.
        for (int t = 0; t < 5; t++) begin
            do_reset();
            send_and_check(tab[t], -1);
        end

        // A write of zero is ignored. DEADBEEF written 5 cycles later is reported.
        do_reset();
        csr_wdata = 32'h0;
        csr_we    = 1'b1;
        cyc();
        csr_we = 1'b0;
        check("zero_write_busy",   {31'h0, busy},       32'h0);
        check("zero_write_serial", {31'h0, serial_out}, 32'h1);
        repeat (4) cyc();
        send_and_check(v_beef, -1);

        // A write during the message and a write after done are both ignored.
        do_reset();
        send_and_check(v_pass, 37);
        csr_wdata = 32'h2;
        csr_we    = 1'b1;
        cyc();
        csr_we = 1'b0;
        repeat (200) cyc();
        check("late_rx_count", rx_q.size(),         32'd6);
        check("late_starts",   rx_starts,           32'd6);
        check("late_done",     {31'h0, done},       32'h1);
        check("late_busy",     {31'h0, busy},       32'h0);
        check("late_pass",     {31'h0, pass},       32'h1);
        check("late_serial",   {31'h0, serial_out}, 32'h1);

        // A write on the edge where the last stop bit ends is ignored.
        do_reset();
        send_and_check(v_pass, 600);
        repeat (200) cyc();
        check("edge_write_starts", rx_starts,     32'd6);
        check("edge_write_done",   {31'h0, done}, 32'h1);

        // Reset asserted mid-byte forces the line idle at once. A clean message follows.
        do_reset();
        csr_wdata = 32'h1;
        csr_we    = 1'b1;
        cyc();
        csr_we    = 1'b0;
        csr_wdata = 32'h0;
        repeat (254) cyc();
        check("pre_reset_busy", {31'h0, busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("async_rst_serial", {31'h0, serial_out}, 32'h1);
        check("async_rst_busy",   {31'h0, busy},       32'h0);
        check("async_rst_done",   {31'h0, done},       32'h0);
        check("async_rst_pass",   {31'h0, pass},       32'h0);
        repeat (3) cyc();
        rst_n = 1'b1;
        repeat (100) cyc();
        clear_rx();
        check("post_rst_serial", {31'h0, serial_out}, 32'h1);
        check("post_rst_busy",   {31'h0, busy},       32'h0);
        send_and_check(v_pass, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
`default_nettype wire
